shot_detector: RTL

Framebuffer read-back block for the duck hunt game: on a shot request at the crosshair, it reads the square pixel window around (shot_x, shot_y) from the 160x120, 3-bit framebuffer. It reports whether any pixel in that window has the bird colour, how many do, and where the first one is. The block is the reader on the same pixel store that the bird and hunter draw FSMs write through (x, y, colour). It sits between the hunter/trigger logic and a framebuffer read port.

---
 rtl/duck_hunt_pkg.sv | 30 +++
 rtl/shot_detector_if.sv | 25 ++
 rtl/shot_detector_rd_tag_pipe.sv | 27 ++
 rtl/shot_detector.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/duck_hunt_pkg.sv
// Shared duck hunt definitions: screen geometry, palette, shot detector
// states, read-tag layout and framebuffer address helper.
package duck_hunt_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] BIRD   = 3'b111;
  localparam logic [2:0] HUNTER = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } shot_state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] x;
    logic [6:0] y;
  } rd_tag_t;

  function automatic logic [14:0] fb_addr(input logic [7:0] x, input logic [6:0] y,
                                          input int unsigned w);
    return 15'((32'(y) * w) + 32'(x));
  endfunction

endpackage

// File: rtl/shot_detector_if.sv
// Shot detector bus: trigger request/result plus framebuffer read port.
interface shot_detector_if;
  logic        shot_req;
  logic [7:0]  shot_x;
  logic [6:0]  shot_y;
  logic        ready;
  logic        rd_en;
  logic [14:0] rd_addr;
  logic [2:0]  rd_data;
  logic        done;
  logic        hit;
  logic [5:0]  hit_count;
  logic [7:0]  hit_x;
  logic [6:0]  hit_y;

  modport slave (
    input  shot_req, shot_x, shot_y, rd_data,
    output ready, rd_en, rd_addr, done, hit, hit_count, hit_x, hit_y
  );

  modport master (
    output shot_req, shot_x, shot_y, rd_data,
    input  ready, rd_en, rd_addr, done, hit, hit_count, hit_x, hit_y
  );
endinterface

// File: rtl/shot_detector_rd_tag_pipe.sv
// Delay line carrying {valid, x, y} alongside each framebuffer read so the
// returning pixel can be matched to the position that requested it.
module rd_tag_pipe
  import duck_hunt_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic    clock,
  input  logic    reset,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_stage [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/shot_detector.sv
// Reads the square window around the crosshair from the framebuffer and
// reports whether, how often and where the bird colour appears.
module shot_detector
  import duck_hunt_pkg::*;
#(
  parameter int unsigned SCREEN_W    = duck_hunt_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H    = duck_hunt_pkg::SCREEN_H,
  parameter int unsigned RADIUS      = 1,
  parameter int unsigned RD_LATENCY  = 1,
  parameter logic [2:0]  BIRD_COLOUR = 3'b111
) (
  input logic            clock,
  input logic            reset,
  shot_detector_if.slave sif
);

  localparam int unsigned      SIDE  = 2 * RADIUS + 1;
  localparam logic [5:0]       N_POS = 6'(SIDE * SIDE);
  localparam logic [5:0]       LAT   = 6'(RD_LATENCY);
  localparam logic signed [3:0] R_POS = 4'(RADIUS);
  localparam logic signed [3:0] R_NEG = -R_POS;

  shot_state_t        r_state;
  logic [7:0]         r_x;
  logic [6:0]         r_y;
  logic signed [3:0]  r_dx, r_dy;
  logic [5:0]         r_cnt;
  logic               r_rd_en;
  logic [14:0]        r_rd_addr;
  logic               r_done;
  logic               r_hit;
  logic [5:0]         r_hit_count;
  logic [7:0]         r_hit_x;
  logic [6:0]         r_hit_y;

  logic               w_ready, w_accept, w_issue, w_on, w_match;
  logic [7:0]         w_base_x;
  logic [6:0]         w_base_y;
  logic signed [3:0]  w_dx, w_dy, w_ndx, w_ndy;
  logic signed [8:0]  w_px;
  logic signed [7:0]  w_py;
  rd_tag_t            w_tag_in, w_tag_out;

  assign w_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept = w_ready && sif.shot_req;
  assign w_issue  = w_accept || ((r_state == S_ISSUE) && (r_cnt < N_POS));

  // Slot 0 is issued straight from the request inputs on the accepting edge,
  // so slot k's read strobe is registered on edge E0+k.
  always_comb begin
    w_base_x = w_accept ? sif.shot_x : r_x;
    w_base_y = w_accept ? sif.shot_y : r_y;
    w_dx     = w_accept ? R_NEG : r_dx;
    w_dy     = w_accept ? R_NEG : r_dy;
    w_px     = $signed({1'b0, w_base_x}) + 9'(w_dx);
    w_py     = $signed({1'b0, w_base_y}) + 8'(w_dy);
    w_on     = !w_px[8] && (32'(w_px[7:0]) < SCREEN_W) &&
               !w_py[7] && (32'(w_py[6:0]) < SCREEN_H);
    if (w_dx == R_POS) begin
      w_ndx = R_NEG;
      w_ndy = w_dy + 4'sd1;
    end else begin
      w_ndx = w_dx + 4'sd1;
      w_ndy = w_dy;
    end
    w_tag_in = '{valid: w_issue && w_on, x: w_px[7:0], y: w_py[6:0]};
  end

  rd_tag_pipe #(.DEPTH(RD_LATENCY)) u_tag_pipe (
    .clock (clock),
    .reset (reset),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  assign w_match = w_tag_out.valid && (sif.rd_data == BIRD_COLOUR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_cnt       <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_done      <= 1'b0;
      r_hit       <= 1'b0;
      r_hit_count <= '0;
      r_hit_x     <= '0;
      r_hit_y     <= '0;
    end else begin
      r_done  <= 1'b0;
      r_rd_en <= w_tag_in.valid;
      if (w_tag_in.valid) r_rd_addr <= fb_addr(w_tag_in.x, w_tag_in.y, SCREEN_W);

      if (w_accept) begin
        r_state     <= S_ISSUE;
        r_x         <= sif.shot_x;
        r_y         <= sif.shot_y;
        r_dx        <= w_ndx;
        r_dy        <= w_ndy;
        r_cnt       <= 6'd1;
        r_hit       <= 1'b0;
        r_hit_count <= '0;
        r_hit_x     <= '0;
        r_hit_y     <= '0;
      end else begin
        case (r_state)
          S_ISSUE: begin
            if (r_cnt < N_POS) begin
              r_dx  <= w_ndx;
              r_dy  <= w_ndy;
              r_cnt <= r_cnt + 6'd1;
            end else begin
              r_state <= S_DRAIN;
              r_cnt   <= 6'd1;
            end
          end
          S_DRAIN: begin
            if (r_cnt == LAT) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: ;
        endcase

        if (w_match) begin
          if (r_hit_count != '1) r_hit_count <= r_hit_count + 6'd1;
          if (!r_hit) begin
            r_hit   <= 1'b1;
            r_hit_x <= w_tag_out.x;
            r_hit_y <= w_tag_out.y;
          end
        end
      end
    end
  end

  assign sif.ready     = w_ready;
  assign sif.rd_en     = r_rd_en;
  assign sif.rd_addr   = r_rd_addr;
  assign sif.done      = r_done;
  assign sif.hit       = r_hit;
  assign sif.hit_count = r_hit_count;
  assign sif.hit_x     = r_hit_x;
  assign sif.hit_y     = r_hit_y;

endmodule
